// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
// Holds the arbiter state encoding so the top and any future observers agree on it.
package mem_port_arbiter_pkg;

  localparam int unsigned AW_DEF    = 32;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_WAIT = 3'd1,
    ST_D_DONE = 3'd2,
    ST_I_WAIT = 3'd3,
    ST_I_DONE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with async active-low clear; one cycle from inc to count.
// Holds at all-ones once reached and never wraps; only the clear brings it back.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM onto one req/ack memory port; data wins, >=3 cycles request to valid.
// Stalls are combinational; the memory may hold off m_ack indefinitely and the requester stays stalled.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic [DW-1:0]    if_rdata,
  output logic             if_valid,
  output logic             if_stall,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_wdata,
  output logic [DW-1:0]    d_rdata,
  output logic             d_valid,
  output logic             d_stall,
  input  logic             flush,
  output logic             m_req,
  output logic             m_we,
  output logic [AW-1:0]    m_addr,
  output logic [DW-1:0]    m_wdata,
  input  logic             m_ack,
  input  logic [DW-1:0]    m_rdata,
  output logic [CNT_W-1:0] stall_cnt
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       drop;
  logic       if_pulse;
  logic       d_req;

  assign d_req = d_read | d_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A fetch squashed while in flight (or at the ack itself) returns straight to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (d_req) begin
          state_nxt = ST_D_WAIT;
        end else if (if_req) begin
          state_nxt = ST_I_WAIT;
        end
      end
      ST_D_WAIT: begin
        if (m_ack) begin
          state_nxt = ST_D_DONE;
        end
      end
      ST_D_DONE: state_nxt = ST_IDLE;
      ST_I_WAIT: begin
        if (m_ack) begin
          state_nxt = (drop || flush) ? ST_IDLE : ST_I_DONE;
        end
      end
      ST_I_DONE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      d_rdata  <= '0;
      if_rdata <= '0;
      d_valid  <= 1'b0;
      if_pulse <= 1'b0;
      drop     <= 1'b0;
    end else begin
      d_valid  <= (state_nxt == ST_D_DONE);
      if_pulse <= (state_nxt == ST_I_DONE);
      case (state)
        ST_IDLE: begin
          if (d_req) begin
            m_req   <= 1'b1;
            m_we    <= d_write;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (if_req) begin
            m_req  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= if_addr;
          end
        end
        ST_D_WAIT: begin
          if (m_ack) begin
            m_req   <= 1'b0;
            d_rdata <= m_rdata;
          end
        end
        ST_I_WAIT: begin
          if (m_ack) begin
            m_req    <= 1'b0;
            if_rdata <= m_rdata;
            drop     <= 1'b0;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Releasing if_stall on a flush lets the branch target load into the PC.
  always_comb begin
    d_stall  = d_req && (state != ST_D_DONE);
    if_stall = (if_req && (state != ST_I_DONE)) || d_stall;
    if (rst && flush && !d_stall) begin
      if_stall = 1'b0;
    end
    if_valid = if_pulse && !flush;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (if_stall | d_stall),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed test-plan scenarios then randomized traffic, all checked each cycle against a transaction-level model.
// The stall counter is built 4 bits wide so saturation is reachable.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             if_req = 1'b0;
  logic [AW-1:0]    if_addr = '0;
  logic [DW-1:0]    if_rdata;
  logic             if_valid;
  logic             if_stall;
  logic             d_read = 1'b0;
  logic             d_write = 1'b0;
  logic [AW-1:0]    d_addr = '0;
  logic [DW-1:0]    d_wdata = '0;
  logic [DW-1:0]    d_rdata;
  logic             d_valid;
  logic             d_stall;
  logic             flush = 1'b0;
  logic             m_req;
  logic             m_we;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic             m_ack = 1'b0;
  logic [DW-1:0]    m_rdata = '0;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW    (AW),
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .d_stall   (d_stall),
    .flush     (flush),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ack     (m_ack),
    .m_rdata   (m_rdata),
    .stall_cnt (stall_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: an access is either on the bus (busy) or its result is being delivered (dlv).
  typedef enum int {DLV_NONE, DLV_DATA, DLV_FETCH} dlv_t;
  bit            busy      = 1'b0;
  bit            busy_data = 1'b0;
  bit            mdl_drop  = 1'b0;
  dlv_t          dlv       = DLV_NONE;
  bit            e_we      = 1'b0;
  logic [AW-1:0] e_addr    = '0;
  logic [DW-1:0] e_wdata   = '0;
  logic [DW-1:0] e_drdata  = '0;
  logic [DW-1:0] e_irdata  = '0;
  int            stalls    = 0;

  function automatic bit exp_d_stall();
    return (d_read || d_write) && (dlv != DLV_DATA);
  endfunction

  function automatic bit exp_if_stall();
    bit s;
    s = (if_req && (dlv != DLV_FETCH)) || exp_d_stall();
    if (rst && flush && !exp_d_stall()) s = 1'b0;
    return s;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy = 0; busy_data = 0; mdl_drop = 0; dlv = DLV_NONE;
      e_we = 0; e_addr = '0; e_wdata = '0; e_drdata = '0; e_irdata = '0;
      stalls = 0;
    end else begin
      if (exp_d_stall() || exp_if_stall()) stalls++;
      if (dlv != DLV_NONE) begin
        dlv = DLV_NONE;
      end else if (busy) begin
        if (m_ack) begin
          busy = 0;
          if (busy_data) begin
            e_drdata = m_rdata;
            dlv = DLV_DATA;
          end else begin
            e_irdata = m_rdata;
            if (mdl_drop || flush) mdl_drop = 0;
            else dlv = DLV_FETCH;
          end
        end else if (!busy_data && flush) begin
          mdl_drop = 1;
        end
      end else if (d_read || d_write) begin
        busy = 1; busy_data = 1; e_we = d_write; e_addr = d_addr; e_wdata = d_wdata;
      end else if (if_req) begin
        busy = 1; busy_data = 0; e_we = 0; e_addr = if_addr;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("m_req",     m_req,     busy);
    chk("m_we",      m_we,      e_we);
    chk("m_addr",    m_addr,    e_addr);
    chk("m_wdata",   m_wdata,   e_wdata);
    chk("d_valid",   d_valid,   dlv == DLV_DATA);
    chk("if_valid",  if_valid,  (dlv == DLV_FETCH) && !flush);
    chk("d_rdata",   d_rdata,   e_drdata);
    chk("if_rdata",  if_rdata,  e_irdata);
    chk("d_stall",   d_stall,   exp_d_stall());
    chk("if_stall",  if_stall,  exp_if_stall());
    chk("stall_cnt", stall_cnt, (stalls > CMAX) ? CMAX : stalls);
  endtask

  task automatic step(input bit rn, input bit ir, input logic [AW-1:0] ia,
                      input bit dr, input bit dw, input logic [AW-1:0] da,
                      input logic [DW-1:0] wd, input bit fl, input bit ack,
                      input logic [DW-1:0] rd);
    @(negedge clk);
    rst = rn; if_req = ir; if_addr = ia; d_read = dr; d_write = dw;
    d_addr = da; d_wdata = wd; flush = fl; m_ack = ack; m_rdata = rd;
    #1;
    compare_all();
  endtask

  task automatic idle_step(input bit rn);
    step(rn, 0, '0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  initial begin
    idle_step(0);
    chk("lit_reset_m_req", m_req, 0);
    chk("lit_reset_cnt", stall_cnt, 0);
    idle_step(1);

    // Lone fetch of 0x40, acked two cycles after m_req rises.
    step(1, 1, 32'h40, 0, 0, '0, '0, 0, 0, '0);
    step(1, 1, 32'h40, 0, 0, '0, '0, 0, 0, '0);
    chk("lit_fetch_req", {m_req, m_we, m_addr}, {1'b1, 1'b0, 32'h40});
    step(1, 1, 32'h40, 0, 0, '0, '0, 0, 1, 32'h8C220004);
    step(1, 1, 32'h40, 0, 0, '0, '0, 0, 0, '0);
    chk("lit_fetch_valid", {if_valid, if_stall}, 2'b10);
    chk("lit_fetch_rdata", if_rdata, 32'h8C220004);
    idle_step(1);

    // Data read and fetch collide: data first, fetch after D_DONE.
    step(1, 1, 32'h80, 1, 0, 32'h100, '0, 0, 0, '0);
    step(1, 1, 32'h80, 1, 0, 32'h100, '0, 0, 1, 32'h1234);
    chk("lit_coll_daddr", m_addr, 32'h100);
    step(1, 1, 32'h80, 1, 0, 32'h100, '0, 0, 0, '0);
    chk("lit_coll_dvalid", {d_valid, d_stall, d_rdata}, {1'b1, 1'b0, 32'h1234});
    step(1, 1, 32'h80, 0, 0, '0, '0, 0, 0, '0);
    step(1, 1, 32'h80, 0, 0, '0, '0, 0, 1, 32'h5);
    chk("lit_coll_faddr", {m_req, m_addr}, {1'b1, 32'h80});
    step(1, 0, '0, 0, 0, '0, '0, 0, 0, '0);
    idle_step(1);

    // Store held across four wait cycles.
    step(1, 0, '0, 0, 1, 32'h200, 32'hDEADBEEF, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, '0, 0, 1, 32'h200, 32'hDEADBEEF, 0, (i == 3), '0);
      chk("lit_store_hold", {m_req, m_we, m_wdata}, {1'b1, 1'b1, 32'hDEADBEEF});
    end
    step(1, 0, '0, 0, 1, 32'h200, 32'hDEADBEEF, 0, 0, '0);
    chk("lit_store_done", {d_valid, if_valid}, 2'b10);
    idle_step(1);

    // Flush while the fetch waits: result discarded, next fetch granted right after ack.
    step(1, 1, 32'h44, 0, 0, '0, '0, 0, 0, '0);
    step(1, 1, 32'h44, 0, 0, '0, '0, 1, 0, '0);
    chk("lit_flush_ifstall", if_stall, 0);
    step(1, 1, 32'h60, 0, 0, '0, '0, 0, 1, 32'hBAD);
    step(1, 1, 32'h60, 0, 0, '0, '0, 0, 0, '0);
    chk("lit_flush_noval", {if_valid, m_req}, 2'b00);
    step(1, 1, 32'h60, 0, 0, '0, '0, 0, 0, '0);
    chk("lit_flush_regrant", {m_req, m_addr}, {1'b1, 32'h60});
    step(1, 0, '0, 0, 0, '0, '0, 0, 1, 32'h7);
    idle_step(1);
    idle_step(1);

    // Reset mid data access, then a late ack that must be ignored.
    step(1, 0, '0, 1, 0, 32'h300, '0, 0, 0, '0);
    step(1, 0, '0, 1, 0, 32'h300, '0, 0, 0, '0);
    idle_step(0);
    chk("lit_rst_mid", {m_req, d_valid, stall_cnt}, 6'b0);
    step(1, 0, '0, 0, 0, '0, '0, 0, 1, 32'h99);
    idle_step(1);
    chk("lit_rst_late_ack", {m_req, d_valid, d_rdata, stall_cnt}, 38'b0);

    // Saturation: data read never acked.
    idle_step(0);
    for (int i = 0; i < 20; i++) step(1, 0, '0, 1, 0, 32'h400, '0, 0, 0, '0);
    chk("lit_sat", stall_cnt, 4'hF);
    idle_step(0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      bit rn, ack;
      rn  = ($urandom_range(0, 299) != 0);
      ack = busy ? ($urandom_range(0, 2) == 0)
                 : ((dlv == DLV_NONE) && ($urandom_range(0, 15) == 0));
      step(rn, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom, $urandom,
           $urandom_range(0, 5) == 0, ack, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the IF stage (instruction fetch) and the MEM stage (lw/sw).
- Sequences each access over a req/ack memory handshake.
- Generates if_stall/d_stall, which the pipeline ORs into its PC-write and pipeline-register write enables.
- Honours the branch/jump flush so that a squashed fetch is discarded rather than delivered.

Parameters:
AW, 32, address width
DW, 32, data width
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
if_req  in  1  IF stage wants an instruction
if_addr  in  AW  fetch address (PC)
if_rdata  out  DW  fetched instruction, valid when if_valid=1
if_valid  out  1  one-cycle pulse, fetch complete
if_stall  out  1  freeze PC and IF/ID
d_read  in  1  MEM-stage MemRead
d_write  in  1  MEM-stage MemWrite
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid when d_valid=1
d_valid  out  1  one-cycle pulse, data access complete
d_stall  out  1  freeze the whole pipeline up to and including MEM
flush  in  1  taken branch/jump squash (the hazard logic's flush signal)
m_req  out  1  memory request, held until m_ack
m_we  out  1  1 = write
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_ack  in  1  one-cycle completion pulse from memory
m_rdata  in  DW  read data, valid with m_ack
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset is asynchronous, active-low.
  - Registered outputs clear on reset: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, stall_cnt=0, drop=0.
  - Reset mid-transaction abandons the access. Any m_ack arriving while in IDLE is ignored.
- State machine: IDLE, D_WAIT, D_DONE, I_WAIT, I_DONE. One outstanding access at most.
- IDLE arbitration, at most one grant per cycle:
  - Data has fixed priority over fetch, because MEM holds the older instruction.
  - If d_read|d_write: register m_req=1, m_addr=d_addr, m_wdata=d_wdata, m_we=d_write, and go to D_WAIT.
  - If d_read and d_write are both set, the write wins.
  - Else if if_req: register m_req=1, m_we=0, m_addr=if_addr, and go to I_WAIT.
- m_req, m_we, m_addr and m_wdata stay stable from grant until the cycle m_ack is seen.
  - m_req drops at the clock edge that samples m_ack.
- D_WAIT:
  - On m_ack, capture d_rdata=m_rdata (writes capture as well; the value is don't-care) and go to D_DONE.
  - d_valid=1 for exactly the D_DONE cycle; then return to IDLE.
  - No new grant is made in D_DONE.
- I_WAIT:
  - On m_ack, capture if_rdata. If drop=0, go to I_DONE; if drop=1, go to IDLE and clear drop.
  - I_DONE pulses if_valid for one cycle, then returns to IDLE.
- Flush:
  - flush=1 in I_WAIT sets drop.
  - flush=1 in I_DONE suppresses if_valid that cycle.
  - flush in IDLE or D_* has no effect on the arbiter.
  - flush coinciding with m_ack in I_WAIT counts as dropped.
- Stall outputs are combinational from state and inputs:
  - d_stall = (d_read|d_write) & (state != D_DONE).
  - if_stall = (if_req & (state != I_DONE)) | d_stall, except that if_stall is forced 0 in any cycle where flush=1 and d_stall=0, so the branch target loads into the PC.
  - During reset: d_stall=d_read|d_write and if_stall=if_req|d_stall.
- Minimum access latency, request to valid: 3 cycles (grant edge, earliest ack one cycle later, DONE cycle).
- stall_cnt increments on every cycle where if_stall|d_stall, saturates at all-ones and never wraps. It is cleared only by reset.

Decomposition:
- Shared package (pipeline pkg): arbiter state enum (3-bit: IDLE, D_WAIT, D_DONE, I_WAIT, I_DONE) and the AW/DW defaults.
- One sub-module, sat_counter (width CNT_W, inc, async active-low clear), instantiated for stall_cnt.
- The FSM, request registers and capture registers stay in mem_port_arbiter.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x40, m_ack 2 cycles after m_req, m_rdata=0x8C220004 -> m_req=1/m_we=0/m_addr=0x40 until ack; if_valid pulses once with if_rdata=0x8C220004; if_stall=0 only in I_DONE.
- Collision: d_read=1 (d_addr=0x100) and if_req=1 in the same IDLE cycle -> data granted first (m_addr=0x100); fetch granted on the cycle after D_DONE.
- Store: d_write=1, d_addr=0x200, d_wdata=0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF held stable across 4 wait cycles; d_valid one pulse; no if_valid.
- Flush during fetch: flush pulsed in I_WAIT -> no if_valid on ack; if_stall=0 in the flush cycle; the next fetch is granted in the cycle after ack.
- Reset mid-access: rst=0 during D_WAIT, late m_ack after release -> outputs at reset values; the ack is ignored; stall_cnt=0.
- Saturation (CNT_W=4): hold d_read with memory never acking for 20 cycles -> stall_cnt reaches 0xF and stays there.
